// File: rtl/led_play_sequencer.sv
// ----------------------------------------------------------------------------
// led_play_sequencer
//   Playback controller for the LED pattern memory. A start pulse walks the
//   memory read port from address 0 up to a latched last address. Each fetched
//   pattern is held on the LEDs for a latched number of cycles. The run then
//   either finishes with a done pulse or wraps around and loops. A stop pulse
//   aborts the run and blanks the LEDs.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset
//   start      one-cycle pulse, begins playback (honoured only when idle)
//   stop       one-cycle pulse, aborts playback / blanks LEDs; beats start
//   loopEn     1 = wrap to address 0 after lastAddr, 0 = one-shot
//   lastAddr   final address played
//   holdTicks  cycles each pattern is held (0 behaves as 1)
//   addrRd     memory read address
//   dataRd     memory read data, valid one cycle after addrRd
//   outPattern registered LED drive
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse when a one-shot run completes normally
// ----------------------------------------------------------------------------
module led_play_sequencer #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int TICK_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              loopEn,
    input  logic [ADDR_W-1:0] lastAddr,
    input  logic [TICK_W-1:0] holdTicks,
    output logic [ADDR_W-1:0] addrRd,
    input  logic [DATA_W-1:0] dataRd,
    output logic [DATA_W-1:0] outPattern,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] LOAD  = 2'd2;
    localparam logic [1:0] HOLD  = 2'd3;

    logic [1:0]        state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] lastAddrL;
    logic              loopEnL;
    logic [TICK_W-1:0] holdL;
    logic [TICK_W-1:0] cnt;

    // The read address simply follows addr, so in IDLE it keeps showing the
    // last address that was played.
    assign addrRd = addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            addr       <= '0;
            lastAddrL  <= '0;
            loopEnL    <= 1'b0;
            holdL      <= '0;
            cnt        <= '0;
            outPattern <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                // Stop beats everything, including a same-cycle start.
                state      <= IDLE;
                busy       <= 1'b0;
                outPattern <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            loopEnL   <= loopEn;
                            lastAddrL <= lastAddr;
                            holdL     <= (holdTicks == '0) ? TICK_W'(1) : holdTicks;
                            addr      <= '0;
                            state     <= FETCH;
                            busy      <= 1'b1;
                        end
                    end
                    FETCH: begin
                        state <= LOAD;
                    end
                    LOAD: begin
                        // Memory data for addr is valid in this cycle.
                        outPattern <= dataRd;
                        cnt        <= holdL - TICK_W'(1);
                        state      <= HOLD;
                    end
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - TICK_W'(1);
                        end else if (addr != lastAddrL) begin
                            addr  <= addr + ADDR_W'(1);
                            state <= FETCH;
                        end else if (loopEnL) begin
                            addr  <= '0;
                            state <= FETCH;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_play_sequencer.sv
// ----------------------------------------------------------------------------
// tb_led_play_sequencer
//   Directed bench for led_play_sequencer with a registered-read 16x16 pattern
//   memory model. Inputs are driven and outputs sampled on the falling edge;
//   cycle numbers c count falling edges after the start-sampling rising edge.
// ----------------------------------------------------------------------------
module tb_led_play_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        stop;
    logic        loopEn;
    logic [3:0]  lastAddr;
    logic [23:0] holdTicks;
    logic [3:0]  addrRd;
    logic [15:0] dataRd;
    logic [15:0] outPattern;
    logic        busy;
    logic        done;

    logic [15:0] mem [16];

    int unsigned checkCnt = 0;
    int unsigned passCnt  = 0;

    led_play_sequencer #(
        .DATA_W(16),
        .ADDR_W(4),
        .TICK_W(24)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stop      (stop),
        .loopEn    (loopEn),
        .lastAddr  (lastAddr),
        .holdTicks (holdTicks),
        .addrRd    (addrRd),
        .dataRd    (dataRd),
        .outPattern(outPattern),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk) dataRd <= mem[addrRd];

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        if (obs === exp) begin
            passCnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic pulseStart();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic pulseStop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    logic [15:0] expPat;
    logic [3:0]  expAddr;
    logic        doneSeen;

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'(16'h0101 * i);
        mem[0] = 16'h0001;
        mem[1] = 16'h00F0;
        mem[2] = 16'hAAAA;

        rst = 1'b1; start = 1'b0; stop = 1'b0;
        loopEn = 1'b0; lastAddr = 4'd2; holdTicks = 24'd3;
        step(); step();
        rst = 1'b0;

        // Reset values
        checkVal("rst_addrRd", 32'(addrRd), 32'd0);
        checkVal("rst_out",    32'(outPattern), 32'd0);
        checkVal("rst_busy",   32'(busy), 32'd0);
        checkVal("rst_done",   32'(done), 32'd0);

        // One-shot, H=3, three entries: 5-cycle steps, busy for 15 cycles
        pulseStart();
        for (int c = 1; c <= 18; c++) begin
            expPat  = (c <= 7) ? 16'h0001 : (c <= 12) ? 16'h00F0 : 16'hAAAA;
            expAddr = (c <= 5) ? 4'd0 : (c <= 10) ? 4'd1 : 4'd2;
            if (c >= 3) checkVal("oneshot_out", 32'(outPattern), 32'(expPat));
            checkVal("oneshot_addr", 32'(addrRd), 32'(expAddr));
            checkVal("oneshot_busy", 32'(busy), (c <= 15) ? 32'd1 : 32'd0);
            checkVal("oneshot_done", 32'(done), (c == 16) ? 32'd1 : 32'd0);
            step();
        end

        // Loop; input changes after start must not affect the run
        loopEn = 1'b1;
        pulseStart();
        for (int c = 1; c <= 18; c++) begin
            if (c == 2) begin
                lastAddr = 4'd15;
                loopEn   = 1'b0;
            end
            if (c == 3)  checkVal("loop_out0", 32'(outPattern), 32'h0001);
            if (c == 8)  checkVal("loop_out1", 32'(outPattern), 32'h00F0);
            if (c == 13) checkVal("loop_out2", 32'(outPattern), 32'hAAAA);
            if (c == 16) checkVal("loop_wrap_addr", 32'(addrRd), 32'd0);
            if (c == 16) checkVal("loop_wrap_busy", 32'(busy), 32'd1);
            if (c == 18) checkVal("loop_out0_again", 32'(outPattern), 32'h0001);
            step();
        end
        doneSeen = 1'b0;
        for (int c = 0; c < 100; c++) begin
            doneSeen = doneSeen | done;
            step();
        end
        checkVal("loop_no_done", 32'(doneSeen), 32'd0);
        checkVal("loop_still_busy", 32'(busy), 32'd1);
        pulseStop();
        checkVal("loopstop_busy", 32'(busy), 32'd0);
        checkVal("loopstop_out",  32'(outPattern), 32'd0);

        // Stop during the second HOLD, then replay from address 0
        loopEn = 1'b0; lastAddr = 4'd2; holdTicks = 24'd3;
        pulseStart();
        for (int c = 1; c < 8; c++) step();
        checkVal("midstop_pre_out",  32'(outPattern), 32'h00F0);
        checkVal("midstop_pre_busy", 32'(busy), 32'd1);
        pulseStop();
        checkVal("midstop_busy", 32'(busy), 32'd0);
        checkVal("midstop_out",  32'(outPattern), 32'd0);
        checkVal("midstop_addr", 32'(addrRd), 32'd1);
        doneSeen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            doneSeen = doneSeen | done | busy;
            step();
        end
        checkVal("midstop_no_done", 32'(doneSeen), 32'd0);
        pulseStart();
        checkVal("replay_addr", 32'(addrRd), 32'd0);
        checkVal("replay_busy", 32'(busy), 32'd1);
        step(); step();
        checkVal("replay_out0", 32'(outPattern), 32'h0001);
        for (int c = 3; c < 16; c++) step();
        checkVal("replay_done", 32'(done), 32'd1);

        // holdTicks=0 behaves as 1: 3-cycle steps over all 16 addresses
        holdTicks = 24'd0; lastAddr = 4'd15; loopEn = 1'b0;
        pulseStart();
        for (int c = 1; c <= 50; c++) begin
            if ((c % 3) == 0 && c <= 48) begin
                expAddr = 4'(c / 3 - 1);
                checkVal("full_addr", 32'(addrRd), 32'(expAddr));
                checkVal("full_out",  32'(outPattern), 32'(mem[expAddr]));
            end
            if (c == 48) checkVal("full_busy_last", 32'(busy), 32'd1);
            if (c == 49) checkVal("full_busy_end",  32'(busy), 32'd0);
            if (c == 49) checkVal("full_done",      32'(done), 32'd1);
            if (c == 50) checkVal("full_done_drop", 32'(done), 32'd0);
            if (c == 50) checkVal("full_keep_out",  32'(outPattern), 32'(mem[15]));
            step();
        end

        // Start and stop together in IDLE: stop wins, LEDs blanked
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        checkVal("both_busy", 32'(busy), 32'd0);
        checkVal("both_out",  32'(outPattern), 32'd0);
        checkVal("both_addr", 32'(addrRd), 32'd15);
        step(); step(); step();
        checkVal("both_busy_later", 32'(busy), 32'd0);

        // Start while busy is ignored; mid-run input changes are ignored
        holdTicks = 24'd3; lastAddr = 4'd2; loopEn = 1'b0;
        pulseStart();
        for (int c = 1; c <= 17; c++) begin
            if (c == 8)  checkVal("rebusy_out1", 32'(outPattern), 32'h00F0);
            if (c == 13) checkVal("rebusy_out2", 32'(outPattern), 32'hAAAA);
            if (c == 15) checkVal("rebusy_busy", 32'(busy), 32'd1);
            if (c == 16) checkVal("rebusy_done", 32'(done), 32'd1);
            if (c == 16) checkVal("rebusy_idle", 32'(busy), 32'd0);
            if (c == 17) checkVal("rebusy_done_drop", 32'(done), 32'd0);
            if (c == 2) begin
                lastAddr  = 4'd0;
                holdTicks = 24'd1;
                loopEn    = 1'b1;
            end
            start = (c == 4);
            step();
        end
        start = 1'b0;

        // Reset mid-HOLD overrides a concurrent start
        holdTicks = 24'd3; lastAddr = 4'd2; loopEn = 1'b0;
        pulseStart();
        step(); step(); step();
        checkVal("rsthold_pre_busy", 32'(busy), 32'd1);
        rst = 1'b1; start = 1'b1;
        step();
        checkVal("rsthold_addr", 32'(addrRd), 32'd0);
        checkVal("rsthold_out",  32'(outPattern), 32'd0);
        checkVal("rsthold_busy", 32'(busy), 32'd0);
        checkVal("rsthold_done", 32'(done), 32'd0);
        step();
        rst = 1'b0; start = 1'b0;
        step();
        checkVal("rsthold_after_busy", 32'(busy), 32'd0);
        checkVal("rsthold_after_out",  32'(outPattern), 32'd0);

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
